// File: rtl/sv32_tlb.sv
// Fully-associative Sv32 TLB sitting between the LSU/fetch units and the
// page table walker. Hits answer one cycle after acceptance; misses issue a
// single walk, install the returned leaf as a 4 KiB entry and then answer.
// Optional hit/miss counters are compiled in with `define TLB_STATS_EN.
module sv32_tlb #(
  parameter int ENTRIES    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  satp_en_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_vaddr_i,
  input  logic [1:0]            req_acc_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] rsp_paddr_o,
  output logic                  rsp_fault_o,
  output logic                  walk_req_valid_o,
  input  logic                  walk_req_ready_i,
  output logic [ADDR_WIDTH-1:0] walk_req_addr_o,
  output logic [19:0]           walk_req_vpn_o,
  input  logic                  walk_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] walk_rsp_pte_i,
  input  logic                  walk_rsp_error_i
`ifdef TLB_STATS_EN
  ,
  output logic [31:0]           stat_hits_o,
  output logic [31:0]           stat_misses_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, WALK_REQ, WALK_WAIT, RESP} state_e;

  state_e                  state;
  logic [ENTRIES-1:0]      ent_valid;
  logic [ENTRIES-1:0]      ent_super;
  logic [19:0]             ent_vpn   [ENTRIES];
  logic [19:0]             ent_ppn   [ENTRIES];
  logic [3:0]              ent_flags [ENTRIES];  // {D, X, W, R}
  logic [IDX_W-1:0]        rr_ptr;
  logic [ADDR_WIDTH-1:0]   miss_vaddr;
  logic [1:0]              miss_acc;
  logic                    miss_err;

  logic [ADDR_WIDTH-1:0]   lk_vaddr;
  logic [1:0]              lk_acc;
  logic                    lk_hit;
  logic [IDX_W-1:0]        lk_idx;
  logic                    lk_ok;
  logic [ADDR_WIDTH-1:0]   lk_paddr;
  logic [IDX_W-1:0]        vic_idx;
  logic                    vic_free;
  logic                    accept;
  logic                    inst_en;
  logic                    unused_bits;

  // Access type 3 is treated as a read; writes also require the dirty bit.
  function automatic logic perm_ok(input logic [1:0] acc, input logic [3:0] fl);
    case (acc)
      2'd1:    return fl[1] & fl[3];
      2'd2:    return fl[2];
      default: return fl[0];
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] xlate(input logic sup, input logic [19:0] ppn,
                                                   input logic [ADDR_WIDTH-1:0] va);
    if (sup) return ADDR_WIDTH'({ppn[19:10], va[21:0]});
    else     return ADDR_WIDTH'({ppn, va[11:0]});
  endfunction

  assign req_ready_o      = (state == IDLE) && !rsp_valid_o;
  assign accept           = req_valid_i && req_ready_o;
  assign walk_req_valid_o = (state == WALK_REQ) && !flush_i;
  assign walk_req_addr_o  = walk_req_valid_o ? ADDR_WIDTH'({satp_ppn_i[19:0], 12'h000}) : '0;
  assign walk_req_vpn_o   = walk_req_valid_o ? miss_vaddr[31:12] : '0;
  assign inst_en          = (state == WALK_WAIT) && walk_rsp_valid_i && !walk_rsp_error_i && !flush_i;
  assign unused_bits      = ^{satp_ppn_i[21:20], walk_rsp_pte_i[DATA_WIDTH-1:30],
                              walk_rsp_pte_i[9:8], walk_rsp_pte_i[6:4], walk_rsp_pte_i[0]};

  // Associative lookup: new requests in IDLE, the just-installed miss in RESP.
  // Scanning downwards lets the lowest matching index win.
  always_comb begin
    lk_vaddr = (state == RESP) ? miss_vaddr : req_vaddr_i;
    lk_acc   = (state == RESP) ? miss_acc : req_acc_i;
    lk_hit   = 1'b0;
    lk_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_vpn[i][19:10] == lk_vaddr[31:22] &&
          (ent_super[i] || ent_vpn[i][9:0] == lk_vaddr[21:12])) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
    lk_ok    = perm_ok(lk_acc, ent_flags[lk_idx]);
    lk_paddr = lk_ok ? xlate(ent_super[lk_idx], ent_ppn[lk_idx], lk_vaddr) : '0;
  end

  // Victim: lowest free slot, otherwise the round-robin pointer.
  always_comb begin
    vic_free = 1'b0;
    vic_idx  = rr_ptr;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        vic_free = 1'b1;
        vic_idx  = IDX_W'(i);
      end
    end
  end

  // Control: FSM, entry valid bits, replacement pointer and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ent_valid   <= '0;
      rr_ptr      <= '0;
      miss_err    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_paddr_o <= '0;
      rsp_fault_o <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      ent_valid   <= '0;
      miss_err    <= 1'b0;
      rsp_valid_o <= 1'b0;
    end else begin
      if (rsp_valid_o && rsp_ready_i) rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!satp_en_i) begin
              rsp_valid_o <= 1'b1;
              rsp_paddr_o <= req_vaddr_i;
              rsp_fault_o <= 1'b0;
            end else if (lk_hit) begin
              rsp_valid_o <= 1'b1;
              rsp_paddr_o <= lk_paddr;
              rsp_fault_o <= !lk_ok;
            end else begin
              state <= WALK_REQ;
            end
          end
        end
        WALK_REQ: begin
          if (walk_req_ready_i) state <= WALK_WAIT;
        end
        WALK_WAIT: begin
          if (walk_rsp_valid_i) begin
            miss_err <= walk_rsp_error_i;
            if (!walk_rsp_error_i) begin
              ent_valid[vic_idx] <= 1'b1;
              if (!vic_free) rr_ptr <= rr_ptr + 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          rsp_valid_o <= 1'b1;
          rsp_paddr_o <= miss_err ? '0 : lk_paddr;
          rsp_fault_o <= miss_err || !lk_ok;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: latched miss context and entry payloads (no reset needed).
  always_ff @(posedge clk_i) begin
    if (accept && !flush_i) begin
      miss_vaddr <= req_vaddr_i;
      miss_acc   <= req_acc_i;
    end
    if (inst_en) begin
      ent_super[vic_idx] <= 1'b0;
      ent_vpn[vic_idx]   <= miss_vaddr[31:12];
      ent_ppn[vic_idx]   <= walk_rsp_pte_i[29:10];
      ent_flags[vic_idx] <= {walk_rsp_pte_i[7], walk_rsp_pte_i[3], walk_rsp_pte_i[2], walk_rsp_pte_i[1]};
    end
  end

`ifdef TLB_STATS_EN
  // Saturating hit/miss counters; survive flushes, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_hits_o   <= '0;
      stat_misses_o <= '0;
    end else begin
      if (accept && satp_en_i && lk_hit && !flush_i && stat_hits_o != 32'hFFFF_FFFF)
        stat_hits_o <= stat_hits_o + 32'd1;
      if (walk_req_valid_o && walk_req_ready_i && stat_misses_o != 32'hFFFF_FFFF)
        stat_misses_o <= stat_misses_o + 32'd1;
    end
  end
`endif

endmodule
